// File: rtl/calc_display_pkg.sv
// Shared types and constants for the calculator display stage.
package calc_display_pkg;

    // state | meaning
    // IDLE  | waiting for a rising edge of Done
    // CONV  | double-dabble shifting of the captured result
    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [6:0] SEG_DASH   = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a}; b and d are lowercase
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/calc_display_seg7_decode.sv
// Nibble to active-low 7-segment pattern, with a blanking override.
module seg7_decode
    import calc_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : glyph(nibble);
    end

endmodule

// File: rtl/calc_display.sv
// Captures the calculator result, converts it to BCD and scans a 4-digit display.
// Optional hexadecimal view enabled by defining CALC_DISPLAY_HEX_MODE_EN.
module calc_display
    import calc_display_pkg::*;
#(
    parameter int REFRESH_BITS = 17,
    parameter int CONV_STEPS   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Done,
    input  logic [3:0] Out_H,
    input  logic [3:0] Out_L,
`ifdef CALC_DISPLAY_HEX_MODE_EN
    input  logic       hex_sel,
`endif
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int STEP_W = $clog2(CONV_STEPS + 1);
    localparam int SH_W   = 12 + CONV_STEPS;

    state_t                  state, state_next;
    logic                    done_q;
    logic                    rise;
    logic [SH_W-1:0]         sh, sh_next, shifted;
    logic [11:0]             adj;
    logic [STEP_W-1:0]       step, step_next;
    logic [11:0]             bcd, bcd_next;
    logic [REFRESH_BITS-1:0] refresh;
    logic [1:0]              sel;
    logic [3:0]              digit_nib;
    logic                    digit_blank;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   an_r;
    logic [6:0]              seg_r;

    assign rise = Done & ~done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        adj = sh[SH_W-1 -: 12];
        for (int i = 0; i < 3; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        shifted    = {adj, sh[CONV_STEPS-1:0]} << 1;
        state_next = state;
        sh_next    = sh;
        step_next  = step;
        bcd_next   = bcd;
        // A new edge always wins, even mid-conversion
        if (rise) begin
            state_next = CONV;
            sh_next    = SH_W'({Out_H, Out_L});
            step_next  = '0;
        end else if (state == CONV) begin
            sh_next   = shifted;
            step_next = step + 1'b1;
            if (step == STEP_W'(CONV_STEPS - 1)) begin
                bcd_next   = shifted[SH_W-1 -: 12];
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
            sh     <= '0;
            step   <= '0;
            bcd    <= '0;
        end else begin
            done_q <= Done;
            sh     <= sh_next;
            step   <= step_next;
            bcd    <= bcd_next;
        end
    end

`ifdef CALC_DISPLAY_HEX_MODE_EN
    logic [7:0] cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cap <= '0;
        else if (rise) cap <= {Out_H, Out_L};
    end
`endif

    assign sel = refresh[REFRESH_BITS-1 -: 2];

    always_comb begin
        digit_nib   = bcd[3:0];
        digit_blank = 1'b0;
        case (sel)
            2'd0: begin
                digit_nib   = bcd[3:0];
                digit_blank = 1'b0;
            end
            2'd1: begin
                digit_nib   = bcd[7:4];
                digit_blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
            end
            2'd2: begin
                digit_nib   = bcd[11:8];
                digit_blank = (bcd[11:8] == 4'd0);
            end
            default: digit_blank = 1'b1;
        endcase
`ifdef CALC_DISPLAY_HEX_MODE_EN
        if (hex_sel) begin
            case (sel)
                2'd0: begin
                    digit_nib   = cap[3:0];
                    digit_blank = 1'b0;
                end
                2'd1: begin
                    digit_nib   = cap[7:4];
                    digit_blank = 1'b0;
                end
                default: digit_blank = 1'b1;
            endcase
        end
`endif
    end

    seg7_decode u_dec (
        .nibble (digit_nib),
        .blank  (digit_blank),
        .seg    (dec_seg)
    );

    // an and seg both register off the same sel so they change together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh <= '0;
            an_r    <= '1;
            seg_r   <= SEG_BLANK;
        end else begin
            refresh <= refresh + 1'b1;
            an_r    <= ~(NUM_DIGITS'(1) << sel);
            seg_r   <= dec_seg;
        end
    end

    assign busy = (state == CONV);
    assign an   = an_r;
    assign seg  = seg_r;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_calc_display.sv
// Scoreboard bench for calc_display: random results checked against a decimal/hex digit model.
`timescale 1ns/1ps
module tb_calc_display;

    localparam int RB       = 4;
    localparam int SCAN_LEN = 4 * (1 << (RB - 2));

    logic       clk = 1'b0;
    logic       rst;
    logic       Done;
    logic [3:0] Out_H, Out_L;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
`ifdef CALC_DISPLAY_HEX_MODE_EN
    logic       hex_sel;
`endif

    calc_display #(.REFRESH_BITS(RB), .CONV_STEPS(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .Done  (Done),
        .Out_H (Out_H),
        .Out_L (Out_L),
`ifdef CALC_DISPLAY_HEX_MODE_EN
        .hex_sel (hex_sel),
`endif
        .busy  (busy),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int value;
        bit hex;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    bit         mon_prev;
    int         checks = 0;
    int         passes = 0;
    int         mon_done = 0;
    int         nexp = 0;
    bit         watch200 = 1'b0;
    bit         saw200 = 1'b0;
    logic [3:0] prev_an;
    bit         found;
    int         errs;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, expv);
    endtask

    // Expected segments of digit d (0 = rightmost) for result v
    function automatic logic [6:0] model_seg(input int v, input int d, input bit hex);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        if (hex) begin
            if (d == 0) return glyph_tab[v % 16];
            if (d == 1) return glyph_tab[v / 16];
            return 7'b1111111;
        end
        if (d == 0) return glyph_tab[o];
        if (d == 1) return (h == 0 && t == 0) ? 7'b1111111 : glyph_tab[t];
        if (d == 2) return (h == 0) ? 7'b1111111 : glyph_tab[h];
        return 7'b1111111;
    endfunction

    task automatic check_display(input int v, input bit hex, input string tag);
        logic [27:0] got;
        bit          ok;
        got = '0;
        ok  = 1'b1;
        for (int c = 0; c < SCAN_LEN; c++) begin
            @(negedge clk);
            case (an)
                4'b1110: got[0  +: 7] = seg;
                4'b1101: got[7  +: 7] = seg;
                4'b1011: got[14 +: 7] = seg;
                4'b0111: got[21 +: 7] = seg;
                default: ok = 1'b0;
            endcase
            if (dp !== 1'b1) ok = 1'b0;
        end
        chk($sformatf("%s_an_dp_v%0d", tag, v), int'(ok), 1);
        for (int d = 0; d < 4; d++)
            chk($sformatf("%s_v%0d_digit%0d", tag, v, d), int'(got[7*d +: 7]), int'(model_seg(v, d, hex)));
    endtask

    // Drives Done from the current negedge and counts busy cycles after the capture edge
    task automatic measure_busy(input int hold, input string tag);
        int n;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c + 1 >= hold) Done = 1'b0;
            if (busy) n++;
            else break;
        end
        Done = 1'b0;
        chk({tag, "_busy_cycles"}, n, 8);
    endtask

    task automatic send(input logic [7:0] v, input int hold, input bit hex);
        @(negedge clk);
        Out_H = v[7:4];
        Out_L = v[3:0];
        Done  = 1'b1;
        exp_q.push_back('{value: int'(v), hex: hex});
        measure_busy(hold, "send");
    endtask

    task automatic wait_mon(input int target);
        for (int c = 0; c < 200 && mon_done < target; c++) @(negedge clk);
        chk("monitor_progress", mon_done, target);
    endtask

    initial begin : monitor
        mon_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev = 1'b0;
            end else begin
                if (mon_prev && !busy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", exp_q.size(), 1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        @(negedge clk);
                        check_display(mon_e.value, mon_e.hex, "result");
                    end
                    mon_done++;
                end
                mon_prev = busy;
            end
        end
    end

    always @(negedge clk) begin
        if (watch200 && an == 4'b1011 && seg == glyph_tab[2]) saw200 = 1'b1;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst   = 1'b1;
        Done  = 1'b0;
        Out_H = 4'd0;
        Out_L = 4'd0;
`ifdef CALC_DISPLAY_HEX_MODE_EN
        hex_sel = 1'b0;
`endif
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_an", int'(an), 4'b1111);
        chk("rst_seg", int'(seg), 7'b1111111);
        chk("rst_dp", int'(dp), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        prev_an = 4'b0000;
        found   = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (prev_an == 4'b0111 && an == 4'b1110) found = 1'b1;
            prev_an = an;
        end
        chk("scan_wrap_found", int'(found), 1);
        errs = 0;
        for (int k = 1; k < SCAN_LEN; k++) begin
            @(negedge clk);
            if (an != ~(4'b0001 << (k / 4))) errs++;
        end
        chk("scan_order", errs, 0);
        check_display(0, 1'b0, "idle");

        send(8'hFF, 1, 1'b0); nexp++; wait_mon(nexp);
        send(8'd7, 3, 1'b0);  nexp++; wait_mon(nexp);
        send(8'd100, 1, 1'b0); nexp++; wait_mon(nexp);

        // Restart: 200 captured, then 42 three cycles later; only 42 may ever show
        watch200 = 1'b1;
        saw200   = 1'b0;
        @(negedge clk);
        Out_H = 4'hC; Out_L = 4'h8; Done = 1'b1;
        @(negedge clk);
        Done = 1'b0;
        errs = (busy !== 1'b1) ? 1 : 0;
        repeat (2) begin
            @(negedge clk);
            if (busy !== 1'b1) errs++;
        end
        @(negedge clk);
        Out_H = 4'h2; Out_L = 4'hA; Done = 1'b1;
        exp_q.push_back('{value: 42, hex: 1'b0});
        chk("restart_busy_held", errs, 0);
        measure_busy(1, "restart");
        nexp++;
        wait_mon(nexp);
        watch200 = 1'b0;
        chk("restart_no_200", int'(saw200), 0);

        for (int i = 0; i < 6; i++) begin
            send(8'($urandom_range(0, 255)), int'($urandom_range(1, 12)), 1'b0);
            nexp++;
            wait_mon(nexp);
        end

        // Asynchronous reset in the middle of a conversion
        @(negedge clk);
        Out_H = 4'hF; Out_L = 4'hA; Done = 1'b1;
        @(negedge clk);
        Done = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_before_rst", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_an", int'(an), 4'b1111);
        chk("async_rst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_display(0, 1'b0, "after_rst");

`ifdef CALC_DISPLAY_HEX_MODE_EN
        hex_sel = 1'b1;
        send(8'hA5, 1, 1'b1); nexp++; wait_mon(nexp);
        send(8'($urandom_range(0, 255)), 2, 1'b1); nexp++; wait_mon(nexp);
        hex_sel = 1'b0;
`endif

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
